// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch over a req/ack memory handshake.
// Optional PC_FETCH_STATS_EN adds accept and redirect counters.
`timescale 1ns/100ps
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jmp,
    input  logic [25:0] jmp_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
`ifdef PC_FETCH_STATS_EN
    output logic [31:0] stat_fetches,
    output logic [31:0] stat_redirects,
`endif
    output logic        fetch_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]  state;
    logic [31:0] tcnt;
    logic [31:0] next_pc;
    logic [31:0] br_tgt;
    logic        accept;
    logic        misalign;
    logic        timeout_hit;

    // Handshake outputs follow state so reset drops imem_req immediately.
    assign imem_req    = (state == S_REQ) || (state == S_WAIT);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_HOLD);
    assign fetch_err   = (state == S_ERR);
    assign pc_plus4    = pc + 32'd4;
    assign accept      = instr_valid & instr_ready;
    assign misalign    = jr & (jr_addr[1:0] != 2'b00);
    assign br_tgt      = pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (tcnt == TIMEOUT_CYCLES - 1);

    always_comb begin
        next_pc = pc_plus4;
        priority case (1'b1)
            jr:       next_pc = jr_addr;
            jmp:      next_pc = {pc_plus4[31:28], jmp_index, 2'b00};
            br_taken: next_pc = br_tgt;
            default:  next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
            tcnt  <= '0;
        end else begin
            unique case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    tcnt <= '0;
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= S_HOLD;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= S_HOLD;
                    end else if (timeout_hit) begin
                        state <= S_ERR;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        if (misalign) begin
                            state <= S_ERR;
                        end else begin
                            pc    <= next_pc;
                            state <= S_REQ;
                        end
                    end
                end
                S_ERR:   state <= S_ERR;
                default: state <= S_ERR;
            endcase
        end
    end

`ifdef PC_FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetches   <= '0;
            stat_redirects <= '0;
        end else if (accept) begin
            stat_fetches <= stat_fetches + 32'd1;
            if (next_pc != pc_plus4) begin
                stat_redirects <= stat_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: memory responder, next-pc model, directed tests.
// Stat port checks are compiled when PC_FETCH_STATS_EN is defined.
`timescale 1ns/100ps
module tb_pc_fetch_unit;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        br_taken = 1'b0;
    logic [15:0] br_offset = '0;
    logic        jmp = 1'b0;
    logic [25:0] jmp_index = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = '0;
    logic        fetch_err;
`ifdef PC_FETCH_STATS_EN
    logic [31:0] stat_fetches;
    logic [31:0] stat_redirects;
`endif

    int checks = 0;
    int failures = 0;
    int ack_delay = 0;
    logic force_ack = 1'b0;

    pc_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .br_taken(br_taken),
        .br_offset(br_offset),
        .jmp(jmp),
        .jmp_index(jmp_index),
        .jr(jr),
        .jr_addr(jr_addr),
`ifdef PC_FETCH_STATS_EN
        .stat_fetches(stat_fetches),
        .stat_redirects(stat_redirects),
`endif
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] model_next(
        input logic [31:0] cur, input logic b, input logic [15:0] off,
        input logic j, input logic [25:0] idx,
        input logic r, input logic [31:0] ra);
        logic [31:0] seq;
        logic [31:0] sx;
        seq = cur + 32'd4;
        sx  = {{16{off[15]}}, off};
        if (r) return ra;
        if (j) return {seq[31:28], idx, 2'b00};
        if (b) return seq + sx * 32'd4;
        return seq;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Memory responder: acks after ack_delay request cycles (<0 = never).
    initial begin
        int rc;
        rc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                imem_ack = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
                rc = 0;
            end else if (imem_req) begin
                if (ack_delay >= 0 && rc == ack_delay) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    rc = 0;
                end else begin
                    imem_ack = 1'b0;
                    rc++;
                end
            end else begin
                imem_ack = 1'b0;
                rc = 0;
            end
        end
    end

    // Transaction-level model checked every mid-cycle.
    initial begin
        logic [31:0] m_pc;
        logic        m_err;
        int          req_run;
        logic [31:0] m_fetch;
        logic [31:0] m_redir;
        logic [31:0] nx;
        m_pc = 32'h0; m_err = 1'b0; req_run = 0;
        m_fetch = '0; m_redir = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pc = 32'h0; m_err = 1'b0; req_run = 0;
                m_fetch = '0; m_redir = '0;
            end else begin
                chk("m_pc", pc, m_pc);
                chk("m_err", {31'd0, fetch_err}, {31'd0, m_err});
`ifdef PC_FETCH_STATS_EN
                chk("m_stat_fetches", stat_fetches, m_fetch);
                chk("m_stat_redirects", stat_redirects, m_redir);
`endif
                if (m_err) begin
                    chk("m_err_req", {31'd0, imem_req}, 32'd0);
                    chk("m_err_valid", {31'd0, instr_valid}, 32'd0);
                end
                if (instr_valid) begin
                    chk("m_instr", instr, mem_word(m_pc));
                    chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
                    chk("m_hold_noreq", {31'd0, imem_req}, 32'd0);
                end
                if (imem_req) chk("m_addr", imem_addr, m_pc);
                if (instr_valid && instr_ready) begin
                    nx = model_next(m_pc, br_taken, br_offset, jmp,
                                    jmp_index, jr, jr_addr);
                    m_fetch++;
                    if (nx != m_pc + 32'd4) m_redir++;
                    if (jr && jr_addr[1:0] != 2'b00) m_err = 1'b1;
                    else m_pc = nx;
                end
                if (imem_req) begin
                    if (imem_ack) req_run = 0;
                    else begin
                        req_run++;
                        if (TMO != 0 && req_run == int'(TMO) + 1) m_err = 1'b1;
                    end
                end else begin
                    req_run = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!instr_valid && n < 100) begin
            step();
            n++;
        end
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic do_accept(input logic b, input logic [15:0] off,
                             input logic j, input logic [25:0] idx,
                             input logic r, input logic [31:0] ra);
        wait_valid();
        br_taken = b; br_offset = off; jmp = j; jmp_index = idx;
        jr = r; jr_addr = ra; instr_ready = 1'b1;
        step();
        instr_ready = 1'b0; br_taken = 1'b0; jmp = 1'b0; jr = 1'b0;
    endtask

    task automatic seq_accept();
        do_accept(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] pcs[$];
        logic [31:0] ins[$];
        int nvalid;
        int consec;
        logic prev;

        repeat (3) step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);

        // sequential stream, 1-cycle ack
        rst_n = 1'b1;
        instr_ready = 1'b1;
        nvalid = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (instr_valid) begin
                nvalid++;
                pcs.push_back(pc);
                ins.push_back(instr);
                if (prev) consec++;
            end
            prev = instr_valid;
        end
        instr_ready = 1'b0;
        chk("seq_count", nvalid, 32'd4);
        chk("seq_alt", consec, 32'd0);
        for (int i = 0; i < pcs.size(); i++) chk("seq_pc", pcs[i], 32'(4 * i));
        if (ins.size() > 0) chk("seq_instr0", ins[0], 32'h0000_FFFF);

        // backward branch loop
        seq_accept();
        seq_accept();
        wait_valid();
        chk("loop_start", pc, 32'h14);
        for (int it = 0; it < 5; it++) begin
            do_accept(1'b1, 16'hFFFB, 1'b0, 26'h0, 1'b0, 32'h0);
            wait_valid();
            chk("loop_back", pc, 32'h4);
            repeat (4) seq_accept();
            wait_valid();
            chk("loop_top", pc, 32'h14);
        end
        do_accept(1'b0, 16'hFFFB, 1'b0, 26'h0, 1'b0, 32'h0);
        wait_valid();
        chk("loop_exit", pc, 32'h18);
`ifdef PC_FETCH_STATS_EN
        chk("loop_redirects", stat_redirects, 32'd5);
`endif

        // redirect priority
        do_accept(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0040_0000);
        wait_valid();
        chk("prio_base", pc, 32'h0040_0000);
        do_accept(1'b1, 16'h0010, 1'b1, 26'h10, 1'b1, 32'h100);
        wait_valid();
        chk("prio_jr", pc, 32'h100);
        do_accept(1'b1, 16'h0010, 1'b1, 26'h10, 1'b0, 32'h0);
        wait_valid();
        chk("prio_jmp", pc, 32'h40);

        // stall in HOLD with redirect noise
        for (int i = 0; i < 7; i++) begin
            br_taken = ~br_taken; jmp = 1'b1; jmp_index = 26'h3;
            step();
            chk("stall_pc", pc, 32'h40);
            chk("stall_instr", instr, 32'h0040_FFBF);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        seq_accept();
        wait_valid();
        chk("stall_seq", pc, 32'h44);

        // misaligned jr
        do_accept(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h102);
        chk("mis_err", {31'd0, fetch_err}, 32'd1);
        chk("mis_pc", pc, 32'h44);
        repeat (4) step();
        chk("mis_stuck", {31'd0, fetch_err}, 32'd1);
        chk("mis_noreq", {31'd0, imem_req}, 32'd0);

        // timeout
        rst_n = 1'b0;
        ack_delay = -1;
        step();
        rst_n = 1'b1;
        repeat (17) step();
        chk("tmo_pre_err", {31'd0, fetch_err}, 32'd0);
        chk("tmo_pre_req", {31'd0, imem_req}, 32'd1);
        step();
        chk("tmo_err", {31'd0, fetch_err}, 32'd1);
        chk("tmo_req", {31'd0, imem_req}, 32'd0);
        ack_delay = 0;
        repeat (3) step();
        chk("tmo_stuck", {31'd0, fetch_err}, 32'd1);

        // async reset in WAIT, then late ack
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_valid();
        chk("ar_first", pc, 32'h0);
        ack_delay = 6;
        seq_accept();
        step();
        step();
        chk("ar_wait_req", {31'd0, imem_req}, 32'd1);
        chk("ar_wait_addr", imem_addr, 32'h4);
        force_ack = 1'b1;
        step();
        rst_n = 1'b0;
        #0.5;
        chk("ar_req_drop", {31'd0, imem_req}, 32'd0);
        chk("ar_pc", pc, 32'h0);
        chk("ar_addr", imem_addr, 32'h0);
        #0.5;
        rst_n = 1'b1;
        force_ack = 1'b0;
        ack_delay = 0;
        step();
        wait_valid();
        chk("ar_refetch_pc", pc, 32'h0);
        chk("ar_refetch_instr", instr, 32'h0000_FFFF);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Upstream stage of the single-cycle core's decode/execute path.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Presents one instruction at a time to the core and applies next-PC redirects: sequential, beq/bne branch, j/jal jump, jr register jump.
- Replaces the zero-latency fetch path so imemory can later become a multi-cycle or cached memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- TIMEOUT_CYCLES, 16, max WAIT cycles before fetch_err asserts; 0 disables the timeout.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request, held until imem_ack.
- imem_addr  output  32  word-aligned fetch address, stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr/pc/pc_plus4 hold a valid instruction.
- instr_ready  input  1  core consumes the instruction this cycle.
- instr  output  32  current instruction.
- pc  output  32  address of instr.
- pc_plus4  output  32  pc + 4, used for jal link.
- br_taken  input  1  beq/bne condition true; sampled only on accept.
- br_offset  input  16  raw immediate of the branch.
- jmp  input  1  j/jal; sampled on accept.
- jmp_index  input  26  instr_index field.
- jr  input  1  jr; sampled on accept.
- jr_addr  input  32  rs value.
- fetch_err  output  1  sticky error flag: timeout or misaligned jr target.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0 (nop), fetch_err=0, timeout counter=0.
- FSM states: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: one cycle after reset deasserts, then goes to REQ.
- REQ:
  - Drive imem_req=1 and imem_addr=pc, then go to WAIT.
  - If imem_ack is already high in this cycle, capture the data and go directly to HOLD. Minimum latency is 1 cycle from REQ entry to instr_valid.
- WAIT:
  - imem_req stays 1.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to HOLD.
  - The counter increments every WAIT cycle without ack. When it reaches TIMEOUT_CYCLES: fetch_err<=1, go to ERR.
- HOLD:
  - instr_valid=1; instr, pc and pc_plus4 stay stable until accept.
  - Accept is instr_valid & instr_ready, evaluated at the clock edge.
  - On accept, compute next_pc and set pc<=next_pc, instr_valid<=0, then go to REQ.
- next_pc priority: jr > jmp > br_taken > sequential.
  - jr: jr_addr. If jr_addr[1:0]!=0, set fetch_err<=1 and go to ERR; pc is not updated.
  - jmp: {pc_plus4[31:28], jmp_index, 2'b00}.
  - br_taken: pc_plus4 + ({{14{br_offset[15]}}, br_offset, 2'b00}), modulo 2^32.
  - Otherwise: pc_plus4; wraps 32'hFFFF_FFFC -> 0.
- Redirect inputs are ignored in any cycle without accept.
- Simultaneous redirect inputs are resolved by priority. No error is raised.
- imem_ack outside REQ/WAIT is ignored.
- Under a back-to-back instr_ready=1 steady stream with 1-cycle ack, throughput is one instruction per 2 cycles.
- ERR:
  - Terminal state: imem_req=0, instr_valid=0, fetch_err=1.
  - Exit only by reset.
- Reset mid-operation:
  - An outstanding request is abandoned and imem_req drops asynchronously.
  - A late imem_ack after reset release is ignored because the FSM is in IDLE.
- pc_plus4 is combinational pc+4.

Optional Feature:
- Macro: PC_FETCH_STATS_EN.
- Defined:
  - Adds outputs stat_fetches[31:0] and stat_redirects[31:0], both reset to 0.
  - stat_fetches increments on each accept.
  - stat_redirects increments on each accept whose next_pc != pc_plus4 (taken branch, jump or jr).
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent, with no other behavioural change.

Test Plan:
- Sequential fetch: 1-cycle ack memory, instr_ready=1, words 0..3 -> pc sequence 0,4,8,12; instr matches memory; instr_valid pulses every 2nd cycle.
- Backward beq loop: at pc=0x14, br_taken=1 with br_offset=16'hFFFB (-5) -> next pc=0x04. Repeat 5 iterations with br_taken=1, then one with br_taken=0 -> pc=0x18. stat_redirects=5 with PC_FETCH_STATS_EN.
- Priority: pc=0x0040_0000 with jr=1 (jr_addr=0x100), jmp=1 (jmp_index=0x10) and br_taken=1 at accept -> pc=0x100. Drop jr on the next accept -> pc={4'h0,0x10,2'b00}=0x40.
- Stall/hold: instr_ready=0 for 7 cycles in HOLD, toggling br_taken -> instr/pc unchanged, no new imem_req, redirect ignored; instr_ready=1 -> sequential pc+4.
- Timeout/misalign: ack withheld 16 WAIT cycles -> fetch_err=1, imem_req=0, state stuck until reset. Separately, jr_addr=0x102 on accept -> fetch_err=1 with pc unchanged.
- Async reset mid-WAIT: rst_n low for 1 ns between edges -> imem_req=0 and pc=RESET_PC immediately. Late imem_ack after release is ignored; the first fetch after release is at RESET_PC.
